// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_controller_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  // Encoding that stops fetch once it has been captured into the buffer.
  localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  // A fetch address is usable only when it lies inside instruction memory.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/fetch_controller_fetch_buffer.sv
// Single-entry valid/ready register slice holding one fetched instruction and its PC.
// Latency: one cycle from load to o_valid; a flush empties it on the next edge.
// Backpressure: contents held while o_valid && !i_ready; slot free when empty or draining.
module fetch_controller_fetch_buffer
  import fetch_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_flush,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_slot_free
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  // The slot can take a new word when nothing is held or the held word leaves this cycle.
  assign o_slot_free = !r_valid || i_ready;

  // Valid bit: flush wins over load; an accepted word with no replacement empties the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload: only written on load, so a stalled or flushed word never changes underneath decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load && !i_flush) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the word-addressed PC, drives instruction memory, handles redirect/halt/fault.
// Latency: first instruction valid one cycle after reset release; 1 instruction/cycle sustained.
// Backpressure: out_ready low holds buffer, PC and imem_addr; redirect flushes even while stalled.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned        IMEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0]  RESET_PC   = 32'd0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        fetch_count
);

  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(IMEM_DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [31:0]       r_fetch_count;

  logic w_slot_free;
  logic w_try_fetch;
  logic w_in_range;
  logic w_capture;
  logic w_handshake;

  // A fetch attempt is made only when running in FETCH with room in the buffer.
  assign w_try_fetch = (r_state == FETCH) && run && w_slot_free;
  assign w_in_range  = addr_in_range(r_pc, LP_DEPTH);
  assign w_handshake = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next PC and capture strobe; redirect overrides every other condition.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = FETCH;
      w_pc_nxt    = redirect_addr;
    end else if (w_try_fetch) begin
      if (w_in_range) begin
        w_capture = 1'b1;
        w_pc_nxt  = r_pc + 32'd1;
        if (imem_rdata == HALT_INSTR) begin
          w_state_nxt = HALTED;
        end
      end else begin
        w_state_nxt = FAULT;
      end
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // Delivered-instruction counter; counts a handshake even in a redirect cycle, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
    end else if (w_handshake) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  fetch_controller_fetch_buffer u_fetch_buffer (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (redirect_valid),
    .i_load      (w_capture),
    .i_instr     (imem_rdata),
    .i_pc        (r_pc),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_instr     (out_instr),
    .o_pc        (out_pc),
    .o_slot_free (w_slot_free)
  );

  assign imem_addr   = r_pc;
  assign halted      = (r_state == HALTED);
  assign fault       = (r_state == FAULT);
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a handshake scoreboard.
// Latency: n/a.
// Backpressure: driven directly from the stimulus sequence.
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_controller #(
    .IMEM_DEPTH (256),
    .RESET_PC   (32'd0),
    .HALT_INSTR (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  // Combinational instruction memory model.
  assign imem_rdata = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    run            = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every handshake must match the next expected instruction in order.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_handshake actual_pc=%h actual_instr=%h expected=none", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hs_pc", out_pc, e.pc);
        chk("hs_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;

    // Reset state
    reset          = 1'b1;
    run            = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'd0;
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // Streaming at full rate
    for (int i = 0; i < 4; i++) push(i, 32'h100 + i);
    reset     = 1'b0;
    run       = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'd0);
    tick();
    tick();
    tick();
    run = 1'b0;
    tick();
    chk("stream_count", fetch_count, 32'd4);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);
    chk("stream_imem_addr", imem_addr, 32'd4);

    // Stall for 3 cycles, resume, then redirect while stalled on pc 5
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", out_pc, 32'd0);
      chk("stall_instr", out_instr, 32'h100);
      chk("stall_imem_addr", imem_addr, 32'd1);
    end
    for (int i = 0; i < 5; i++) push(i, 32'h100 + i);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    chk("pc5_held", out_pc, 32'd5);
    chk("pc5_imem_addr", imem_addr, 32'd6);
    tick();
    chk("pc5_still", out_pc, 32'd5);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h20;
    tick();
    chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h20);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    push(32'h20, 32'h120);
    tick();
    chk("redir_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_pc", out_pc, 32'h20);
    run = 1'b0;
    tick();
    chk("redir_count", fetch_count, 32'd6);

    // Halt at pc 3, then redirect out of HALTED
    mem[3] = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 3; i++) push(i, 32'h100 + i);
    push(3, 32'hFFFF_FFFF);
    run       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_buf_pc", out_pc, 32'd3);
    tick();
    chk("halt_no_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_imem_addr", imem_addr, 32'd4);
    tick();
    tick();
    chk("halt_still_no_valid", {31'd0, out_valid}, 32'd0);
    chk("halt_count", fetch_count, 32'd4);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h10;
    push(32'h10, 32'h110);
    tick();
    redirect_valid = 1'b0;
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_imem_addr", imem_addr, 32'h10);
    tick();
    chk("unhalt_valid", {31'd0, out_valid}, 32'd1);
    chk("unhalt_pc", out_pc, 32'h10);
    run = 1'b0;
    tick();
    chk("unhalt_count", fetch_count, 32'd5);
    mem[3] = 32'h103;

    // Last legal word, then out-of-range fault
    run            = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'd255;
    push(32'd255, 32'h1FF);
    tick();
    redirect_valid = 1'b0;
    chk("edge_imem_addr", imem_addr, 32'd255);
    tick();
    chk("edge_valid", {31'd0, out_valid}, 32'd1);
    chk("edge_pc", out_pc, 32'd255);
    tick();
    chk("fault_flag", {31'd0, fault}, 32'd1);
    chk("fault_no_valid", {31'd0, out_valid}, 32'd0);
    chk("fault_count", fetch_count, 32'd6);
    tick();
    tick();
    chk("fault_hold", {31'd0, fault}, 32'd1);
    chk("fault_count_hold", fetch_count, 32'd6);
    do_reset();
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    chk("fault_rst_imem_addr", imem_addr, 32'd0);
    run       = 1'b1;
    out_ready = 1'b1;
    push(32'd0, 32'h100);
    tick();
    chk("restart_pc", out_pc, 32'd0);
    run = 1'b0;
    tick();

    // Reset during a stall with a pending redirect
    do_reset();
    run = 1'b1;
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_instr", out_instr, 32'd0);
    chk("midrst_pc", out_pc, 32'd0);
    chk("midrst_imem_addr", imem_addr, 32'd0);
    chk("midrst_count", fetch_count, 32'd0);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    chk("midrst_fault", {31'd0, fault}, 32'd0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    run            = 1'b0;
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequencing front end for the instruction fetch path. Owns the fetch PC, which is word-addressed and advances by 1 per instruction. Drives the address of the combinational instruction memory and registers each returned word into a single-entry fetch buffer. The buffer feeds decode over a valid/ready handshake, while the block also handles branch redirects from execute, halt detection, out-of-range address faults, and a delivered-instruction counter.

Parameters:
IMEM_DEPTH, 256, number of 32-bit words in instruction memory; legal fetch addresses are 0..IMEM_DEPTH-1
RESET_PC, 32'd0, fetch PC loaded on reset
HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that stops fetch after it is delivered

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
run  in  1  fetch enable; when 0 no new capture, buffer contents held
imem_addr  out  32  address to instruction memory; equals fetch_pc, combinational from register
imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle
redirect_valid  in  1  branch/jump taken from execute
redirect_addr  in  32  new fetch PC when redirect_valid=1
out_valid  out  1  fetch buffer holds an instruction for decode
out_ready  in  1  decode accepts the buffer this cycle
out_instr  out  32  buffered instruction
out_pc  out  32  address the buffered instruction was fetched from
halted  out  1  state == HALTED
fault  out  1  state == FAULT
fetch_count  out  32  number of completed out handshakes since reset

Behaviour:
- States: FETCH, HALTED, FAULT. Reset → FETCH.
- Reset values: fetch_pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_count=0, halted=0, fault=0.
- Reset mid-operation overrides everything, including redirect and a pending handshake.
- Handshake: a transfer occurs when out_valid && out_ready. It increments fetch_count, which wraps at 2^32.
- Buffer slot free = !out_valid || out_ready.
- Capture condition: state==FETCH && run && slot free && fetch_pc < IMEM_DEPTH. On capture, in the next cycle:
  - out_instr=imem_rdata, out_pc=fetch_pc, out_valid=1
  - fetch_pc=fetch_pc+1
- Capture latency: first instruction is at out_valid=1 one cycle after reset deasserts, with out_pc=RESET_PC. Sustained throughput is 1 instruction/cycle while out_ready=1.
- Stall: out_valid && !out_ready. Buffer, fetch_pc and imem_addr are held stable.
- Slot free but no capture: out_valid goes 0 if the buffer was drained.
- Redirect (priority over capture, stall, HALTED and FAULT):
  - next cycle fetch_pc=redirect_addr, out_valid=0 (the buffered instruction is flushed even when stalled), state=FETCH
  - a handshake in the same cycle still counts
  - no capture occurs in the redirect cycle
- Halt: when the captured imem_rdata == HALT_INSTR, it is captured normally and state → HALTED.
  - HALTED: no further capture; the buffered HALT_INSTR remains deliverable; fetch_pc holds (already incremented).
  - Exit only via redirect or reset.
- Fault: state==FETCH && run && slot free && fetch_pc >= IMEM_DEPTH → state FAULT next cycle, no capture.
  - Buffer content already present stays deliverable.
  - Exit only via redirect or reset.
  - Comparison is 32-bit unsigned.
- run=0: state unchanged. The handshake may still drain the buffer; redirect is still honoured.
- fetch_pc increment is 32-bit with wrap. Wrap cannot occur in practice because fault triggers first.

Decomposition:
- Shared package holds:
  - fetch state encoding (FETCH=2'd0, HALTED=2'd1, FAULT=2'd2)
  - the HALT_INSTR encoding constant
  - ADDR_W=32 and INSTR_W=32
- Natural sub-module: fetch_buffer, the single-entry valid/ready register slice with flush. The controller FSM plus PC logic instantiates it. The existing instruction memory module connects to imem_addr/imem_rdata unchanged.

Test Plan:
- Reset, run=1, out_ready=1, memory[i]=32'h100+i → out_pc 0,1,2,3 on consecutive cycles with out_instr 0x100..0x103; fetch_count=4 after 4 handshakes.
- Hold out_ready=0 for 3 cycles after first capture → out_pc stays 0, out_instr 0x100, imem_addr stays 1; releasing ready resumes at pc 1 with no skipped or duplicated instruction.
- Assert redirect_valid with redirect_addr=0x20 while stalled on pc 5 → next cycle out_valid=0, imem_addr=0x20; following cycle out_pc=0x20; pc 5 never handshakes.
- memory[3]=HALT_INSTR → pc 0..3 delivered, halted=1 from cycle after pc 3 capture, no out_valid after the HALT handshake; redirect to 0x10 → halted=0, fetch resumes at 0x10.
- redirect_addr=IMEM_DEPTH-1 → that word delivered, then fault=1, out_valid=0 afterwards, fetch_count stops; reset clears fault and restarts at RESET_PC.
- Assert reset during a stall with out_valid=1 and redirect_valid=1 → next cycle all outputs at reset values, imem_addr=RESET_PC.
